// File: rtl/uart_txfifo_mod_if.sv
// Byte-push and status bundle between an upstream byte producer and the buffered UART transmitter.
interface uart_txfifo_mod_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  iEn;
  logic [7:0]            iData;
  logic                  oFull;
  logic                  oEmpty;
  logic                  oBusy;
  logic                  oOverflow;
  logic [DEPTH_LOG2:0]   oCount;
  logic                  TXD;

  modport master (
    output iEn, iData,
    input  oFull, oEmpty, oBusy, oOverflow, oCount, TXD
  );

  modport slave (
    input  iEn, iData,
    output oFull, oEmpty, oBusy, oOverflow, oCount, TXD
  );
endinterface

// File: rtl/uart_txfifo_mod.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a bit-timed shift FSM.
module uart_txfifo_mod #(
  parameter int BPS_COUNT  = 434,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  uart_txfifo_mod_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = 11;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nx;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic [CNT_W-1:0]      bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic                  full, empty, push, pop, bit_done, txd;

  // Full/empty come from the pre-edge count, so a write while full is dropped even on a pop edge.
  assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.iEn && !full;
  assign bit_done = (bit_cnt == CNT_W'(BPS_COUNT - 1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:  if (!empty) begin
               pop      = 1'b1;
               state_nx = START;
             end
      START: if (bit_done) state_nx = DATA;
      DATA:  if (bit_done && bit_idx == 3'd7) state_nx = STOP;
      STOP:  if (bit_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.iEn && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= bus.iData;
  end

  // Bit timing: counter runs only outside IDLE and restarts at every bit boundary.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state == IDLE || bit_done) bit_cnt <= '0;
      else                           bit_cnt <= bit_cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (bit_done)  bit_idx <= bit_idx + 3'd1;
      if (pop) shift <= mem[rd_ptr];
    end
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shift[bit_idx];
      default: txd = 1'b1;
    endcase
  end

  assign bus.TXD       = txd;
  assign bus.oFull     = full;
  assign bus.oEmpty    = empty;
  assign bus.oBusy     = !empty || (state != IDLE);
  assign bus.oOverflow = overflow;
  assign bus.oCount    = count;
endmodule

// File: tb/tb_uart_txfifo_mod.sv
// Directed bench: a 115200-baud instance for exact frame timing and a fast instance for FIFO corner cases.
module tb_uart_txfifo_mod;
  localparam int BPS_A = 434;
  localparam int BPS_B = 16;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_txfifo_mod_if #(.DEPTH_LOG2(4)) bus_a ();
  uart_txfifo_mod_if #(.DEPTH_LOG2(4)) bus_b ();

  uart_txfifo_mod #(.BPS_COUNT(BPS_A), .DEPTH_LOG2(4)) u_dut_a (.CLOCK(clk), .RESET(rst_a), .bus(bus_a));
  uart_txfifo_mod #(.BPS_COUNT(BPS_B), .DEPTH_LOG2(4)) u_dut_b (.CLOCK(clk), .RESET(rst_b), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  function automatic logic txd_of(input bit sel);
    return sel ? bus_b.TXD : bus_a.TXD;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bus_b.oBusy : bus_a.oBusy;
  endfunction

  function automatic logic [4:0] cnt_of(input bit sel);
    return sel ? bus_b.oCount : bus_a.oCount;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit sel, input logic [7:0] d);
    if (sel) begin bus_b.iEn = 1'b1; bus_b.iData = d; end
    else     begin bus_a.iEn = 1'b1; bus_a.iData = d; end
    @(negedge clk);
    if (sel) bus_b.iEn = 1'b0;
    else     bus_a.iEn = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input bit sel);
    int k = 0;
    while (busy_of(sel) !== 1'b0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", {31'd0, busy_of(sel)}, 32'd0);
  endtask

  task automatic quiet(input bit sel, input int n, output bit saw_low);
    saw_low = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (txd_of(sel) !== 1'b1) saw_low = 1'b1;
    end
  endtask

  // Waits for a start bit, then samples the middle of each of the 10 bit cells.
  task automatic rx(input bit sel, output logic [9:0] bits, output int fall_cyc, output logic [4:0] cnt_fall);
    int bps = sel ? BPS_B : BPS_A;
    int waited = 0;
    bits = '1;
    fall_cyc = -1;
    cnt_fall = '0;
    while (txd_of(sel) !== 1'b0 && waited < 12 * bps + 64) begin
      @(negedge clk);
      waited++;
    end
    if (txd_of(sel) !== 1'b0) begin
      check("rx_start_timeout", 32'd1, 32'd0);
      return;
    end
    fall_cyc = cyc;
    cnt_fall = cnt_of(sel);
    repeat (bps / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bits[k] = txd_of(sel);
      if (k < 9) repeat (bps) @(negedge clk);
    end
  endtask

  initial begin
    vec_t        vecs [6];
    logic [9:0]  bits;
    logic [4:0]  cf;
    int          n, n0, fc;
    int          falls [3];
    bit          low;

    vecs[0] = '{data: 8'h55, frame: 10'b1010101010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h96, frame: 10'b1100101100};
    vecs[4] = '{data: 8'h01, frame: 10'b1000000010};
    vecs[5] = '{data: 8'h80, frame: 10'b1100000000};

    bus_a.iEn = 1'b0; bus_a.iData = '0;
    bus_b.iEn = 1'b0; bus_b.iData = '0;
    #1;
    check("rst_txd",   {31'd0, bus_b.TXD},       32'd1);
    check("rst_count", {27'd0, bus_b.oCount},    32'd0);
    check("rst_empty", {31'd0, bus_b.oEmpty},    32'd1);
    check("rst_full",  {31'd0, bus_b.oFull},     32'd0);
    check("rst_busy",  {31'd0, bus_b.oBusy},     32'd0);
    check("rst_ovf",   {31'd0, bus_b.oOverflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Single 0x55 frame at full baud: exact start edge, bit pattern and busy window.
    push(1'b0, 8'h55);
    n = cyc;
    check("single_busy_after_push", {31'd0, bus_a.oBusy}, 32'd1);
    check("single_count_after_push", {27'd0, bus_a.oCount}, 32'd1);
    rx(1'b0, bits, fc, cf);
    check("single_fall_cycle", fc, n + 1);
    check("single_frame", {22'd0, bits}, {22'd0, 10'b1010101010});
    wait_cyc(n + 4340);
    check("single_busy_last", {31'd0, bus_a.oBusy}, 32'd1);
    @(negedge clk);
    check("single_busy_drop", {31'd0, bus_a.oBusy}, 32'd0);
    check("single_txd_idle", {31'd0, bus_a.TXD}, 32'd1);

    // Three back-to-back pushes: order, frame spacing and occupancy.
    n = 0;
    fork
      begin
        push(1'b0, 8'hA3);
        n = cyc;
        check("order_count0", {27'd0, bus_a.oCount}, 32'd1);
        push(1'b0, 8'h0F);
        check("order_count1", {27'd0, bus_a.oCount}, 32'd1);
        push(1'b0, 8'hFF);
        check("order_count2", {27'd0, bus_a.oCount}, 32'd2);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          logic [7:0] exp_b;
          logic [4:0] exp_c;
          exp_b = (i == 0) ? 8'hA3 : (i == 1) ? 8'h0F : 8'hFF;
          exp_c = (i == 2) ? 5'd0 : 5'd1;
          rx(1'b0, bits, falls[i], cf);
          check("order_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
          check("order_count_at_pop", {27'd0, cf}, {27'd0, exp_c});
        end
      end
    join
    check("order_first_fall", falls[0], n + 1);
    check("order_gap01", falls[1] - falls[0], 4341);
    check("order_gap12", falls[2] - falls[1], 4341);
    wait_idle(1'b0);

    // Frame-shape table on the fast instance.
    for (int v = 0; v < 6; v++) begin
      push(1'b1, vecs[v].data);
      rx(1'b1, bits, fc, cf);
      check("table_frame", {22'd0, bits}, {22'd0, vecs[v].frame});
      wait_idle(1'b1);
    end

    // Push on the pop edge with count=1 keeps count at 1.
    fork
      begin
        push(1'b1, 8'h5A);
        check("pp1_count_a", {27'd0, bus_b.oCount}, 32'd1);
        push(1'b1, 8'hA5);
        check("pp1_count_b", {27'd0, bus_b.oCount}, 32'd1);
      end
      begin
        rx(1'b1, bits, fc, cf);
        check("pp1_byte0", {24'd0, bits[8:1]}, 32'h5A);
        rx(1'b1, bits, fc, cf);
        check("pp1_byte1", {24'd0, bits[8:1]}, 32'hA5);
      end
    join
    wait_idle(1'b1);

    // Overflow: 18 consecutive writes, one pop has happened, so only the 18th is dropped.
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          push(1'b1, 8'(i));
          if (i == 16) begin
            check("ovf_full_at16", {31'd0, bus_b.oFull}, 32'd1);
            check("ovf_count_at16", {27'd0, bus_b.oCount}, 32'd16);
            check("ovf_flag_before", {31'd0, bus_b.oOverflow}, 32'd0);
          end
          if (i == 17) begin
            check("ovf_flag_set", {31'd0, bus_b.oOverflow}, 32'd1);
            check("ovf_count_after", {27'd0, bus_b.oCount}, 32'd16);
          end
        end
      end
      begin
        for (int i = 0; i < 17; i++) begin
          rx(1'b1, bits, fc, cf);
          check("ovf_stream", {24'd0, bits[8:1]}, i);
        end
      end
    join
    wait_idle(1'b1);
    check("ovf_sticky", {31'd0, bus_b.oOverflow}, 32'd1);
    quiet(1'b1, 200, low);
    check("ovf_no_extra_frame", {31'd0, low}, 32'd0);

    // Full FIFO with a write on the IDLE pop edge: write dropped, count 16 -> 15.
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    n0 = 0;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          push(1'b1, 8'h20 + 8'(i));
          if (i == 0) n0 = cyc;
        end
        check("bnd_full", {31'd0, bus_b.oFull}, 32'd1);
        wait_cyc(n0 + 161);
        check("bnd_count_pre", {27'd0, bus_b.oCount}, 32'd16);
        check("bnd_ovf_pre", {31'd0, bus_b.oOverflow}, 32'd0);
        push(1'b1, 8'hEE);
        check("bnd_count_post", {27'd0, bus_b.oCount}, 32'd15);
        check("bnd_ovf_post", {31'd0, bus_b.oOverflow}, 32'd1);
        check("bnd_full_post", {31'd0, bus_b.oFull}, 32'd0);
      end
      begin
        for (int i = 0; i < 17; i++) begin
          rx(1'b1, bits, fc, cf);
          check("bnd_stream", {24'd0, bits[8:1]}, 32'h20 + i);
        end
      end
    join
    wait_idle(1'b1);
    quiet(1'b1, 200, low);
    check("bnd_no_extra_frame", {31'd0, low}, 32'd0);

    // Reset during data bit 3 of 0x3C with 0x99 still queued.
    push(1'b1, 8'h3C);
    n = cyc;
    push(1'b1, 8'h99);
    wait_cyc(n + 70);
    rst_b = 1'b0;
    #1;
    check("mid_rst_txd", {31'd0, bus_b.TXD}, 32'd1);
    check("mid_rst_count", {27'd0, bus_b.oCount}, 32'd0);
    check("mid_rst_busy", {31'd0, bus_b.oBusy}, 32'd0);
    check("mid_rst_empty", {31'd0, bus_b.oEmpty}, 32'd1);
    check("mid_rst_ovf", {31'd0, bus_b.oOverflow}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    fork
      push(1'b1, 8'h81);
      begin
        rx(1'b1, bits, fc, cf);
        check("post_rst_frame", {22'd0, bits}, {22'd0, 10'b1100000010});
      end
    join
    wait_idle(1'b1);
    quiet(1'b1, 200, low);
    check("post_rst_no_remnant", {31'd0, low}, 32'd0);

    // Pointer wrap: 40 bytes streamed while occupancy stays below full.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int k = 0;
          while (bus_b.oCount > 5'd12 && k < 5000) begin
            @(negedge clk);
            k++;
          end
          push(1'b1, 8'(i * 7 + 3));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          rx(1'b1, bits, fc, cf);
          check("wrap_stream", {24'd0, bits[8:1]}, {24'd0, 8'(i * 7 + 3)});
        end
      end
    join
    wait_idle(1'b1);
    check("wrap_no_overflow", {31'd0, bus_b.oOverflow}, 32'd0);
    check("wrap_empty", {31'd0, bus_b.oEmpty}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
